idex_stage: RTL
===============

Name: idex_stage

Overview:
ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS core.
- Captures decoded fields, operands and control from the ID stage.
- Presents the idex* values that the forwarding unit and EX stage consume.
- Stalls PC and IF/ID and injects a bubble when a load is followed by a dependent instruction.

Parameters:
- CTRL_W, 9, width of the packed control bundle {regwr, memwr, memrd, memtoreg, alusrc, regdst, aluop[2:0]}.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ifid_ins  in  32  instruction in ID.
- ifid_pc4  in  32  PC+4 of instruction in ID.
- id_rdata1  in  32  register file read data, rs.
- id_rdata2  in  32  register file read data, rt.
- id_imm  in  32  sign-extended immediate.
- id_ctrl  in  CTRL_W  decoded control bundle.
- flush  in  1  branch/jump taken; squash the instruction in ID.
- ext_stall  in  1  downstream hold, e.g. multi-cycle memory.
- cnt_clr  in  1  clear the stall counter.
- idexins  out  32  registered instruction.
- idexpc4  out  32  registered PC+4.
- idexrs, idexrt, idexrd  out  5 each  registered ins[25:21], ins[20:16], ins[15:11].
- idexdata1, idexdata2, ideximm  out  32 each  registered operands.
- idexctrl  out  CTRL_W  registered control bundle.
- idexregwr, idexmemwr, idexmemrd  out  1 each  aliases of idexctrl bits.
- idexvalid  out  1  1 = real instruction, 0 = bubble.
- pcwr  out  1  PC write enable.
- ifidwr  out  1  IF/ID write enable.
- hazard  out  1  load-use hazard detected this cycle.
- stallcnt  out  CNT_W  saturating count of hazard cycles.

Behaviour:
- Reset: all idex* outputs, idexvalid and stallcnt become 0. A zero instruction is sll $0 (NOP).
- Combinational outputs are defined from the registered state during reset.
- Load-use detection (combinational from current regs):
  - hazard = idexvalid && idexmemrd && idexrt != 0 && (idexrt == ifid_ins[25:21] || (idexrt == ifid_ins[20:16] && rt_is_src)).
  - rt_is_src = 1 for opcode 0x00 (R-type), 0x04 (beq) and 0x05 (bne).
  - rt_is_src = 0 for sw (0x2B), lw, and I-type ALU ops. sw store data is covered by the MEM-stage store-data forward, so lw followed by sw on the same rt must not stall.
- Enables: pcwr = ifidwr = !(hazard || ext_stall).
- Register update priority, highest first:
  1. rst: clear as above.
  2. ext_stall: hold all idex* state unchanged, even when flush or hazard is asserted. The hazard output still reflects the held state.
  3. flush: load bubble (ins=0, ctrl=0, valid=0, data/imm=0).
  4. hazard: load bubble.
  5. Otherwise: load ID inputs, valid=1.
- Latency: one cycle from ID inputs to idex* outputs.
- A hazard lasts exactly one cycle, because the bubble clears memrd. Back-to-back dependent loads (lw then lw using its result) stall once per pair.
- flush and hazard together: bubble loaded; pcwr=ifidwr=0 from the hazard term. The flush of IF/ID is handled by the IF/ID register.
- stallcnt:
  - Increments by 1 on each cycle with hazard && !ext_stall.
  - Saturates at all-ones.
  - cnt_clr sets it to 0 and takes priority over increment in the same cycle.
- No other internal state.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE=6'h00, OP_BEQ=6'h04, OP_BNE=6'h05, OP_LW=6'h23, OP_SW=6'h2B;
  - CTRL_W and the control-bit index constants;
  - NOP instruction constant 32'h0.
- One sub-module is natural: loaduse_detect, purely combinational, producing hazard. It is reused by the verification scoreboard.

Test Plan:
1. Reset: rst=1 for 2 cycles with nonzero inputs -> all idex* = 0, idexvalid=0, stallcnt=0.
2. lw $8,0($1) then add $9,$8,$2 -> cycle after lw enters EX: hazard=1, pcwr=ifidwr=0. Next cycle: idexins=0, idexvalid=0. Following cycle: add in ID/EX with idexrs=8. stallcnt=1.
3. lw $8 then sw $8,4($3) -> hazard=0, no bubble. lw $8 then sw $4,0($8) -> hazard=1.
4. lw $0 then add $9,$0,$0 -> hazard=0. lw $8 then addi $8,$9,1 (rt not a source) -> hazard=0.
5. ext_stall=1 for 3 cycles during a hazard -> idex* held, pcwr=0, stallcnt unchanged. On release: bubble inserted and stallcnt increments once.
6. Force stallcnt to 16'hFFFF and create another hazard -> stays 16'hFFFF. Assert cnt_clr together with a hazard -> 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline slice around the ID/EX register.
// Holds opcode constants, control-bundle layout, the NOP encoding, the
// ID/EX update-action type and the "rt is a source operand" decode helper.
package mips_pkg;

    // Opcodes consulted by the hazard logic
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Control bundle {regwr, memwr, memrd, memtoreg, alusrc, regdst, aluop[2:0]}
    localparam int unsigned CTRL_W        = 9;
    localparam int unsigned CTRL_REGWR    = 8;
    localparam int unsigned CTRL_MEMWR    = 7;
    localparam int unsigned CTRL_MEMRD    = 6;
    localparam int unsigned CTRL_MEMTOREG = 5;
    localparam int unsigned CTRL_ALUSRC   = 4;
    localparam int unsigned CTRL_REGDST   = 3;
    localparam int unsigned CTRL_ALUOP_LO = 0;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INS = 32'h0000_0000;

    // What the ID/EX register does on the next edge (reset handled separately)
    typedef enum logic [1:0] {
        UPD_LOAD,
        UPD_BUBBLE,
        UPD_HOLD
    } upd_e;

    // rt is read as a source by R-type and by beq/bne. sw store data is
    // excluded on purpose: it is forwarded in MEM, so lw->sw needs no stall.
    function automatic logic rt_is_src(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/idex_stage_loaduse_detect.sv
// Load-use hazard detector (purely combinational).
// Inputs : ex_valid/ex_memrd/ex_rt  - instruction currently in ID/EX
//          id_op/id_rs/id_rt        - fields of the instruction in ID
// Output : hazard - ID instruction consumes the pending load's result
module loaduse_detect
    import mips_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_memrd,
    input  logic [4:0] ex_rt,
    input  logic [5:0] id_op,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       hazard
);

    always_comb begin
        hazard = ex_valid && ex_memrd && (ex_rt != 5'd0) &&
                 ((ex_rt == id_rs) || ((ex_rt == id_rt) && rt_is_src(id_op)));
    end

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Inputs : decoded instruction, PC+4, operands, immediate and control from ID;
//          flush (squash ID), ext_stall (hold everything), cnt_clr.
// Outputs: registered idex* fields for EX/forwarding, idexvalid (0 = bubble),
//          pcwr/ifidwr enables, hazard, saturating stall-cycle counter.
module idex_stage
    import mips_pkg::*;
#(
    parameter int unsigned CTRL_W = mips_pkg::CTRL_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ifid_ins,
    input  logic [31:0]       ifid_pc4,
    input  logic [31:0]       id_rdata1,
    input  logic [31:0]       id_rdata2,
    input  logic [31:0]       id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    input  logic              ext_stall,
    input  logic              cnt_clr,
    output logic [31:0]       idexins,
    output logic [31:0]       idexpc4,
    output logic [4:0]        idexrs,
    output logic [4:0]        idexrt,
    output logic [4:0]        idexrd,
    output logic [31:0]       idexdata1,
    output logic [31:0]       idexdata2,
    output logic [31:0]       ideximm,
    output logic [CTRL_W-1:0] idexctrl,
    output logic              idexregwr,
    output logic              idexmemwr,
    output logic              idexmemrd,
    output logic              idexvalid,
    output logic              pcwr,
    output logic              ifidwr,
    output logic              hazard,
    output logic [CNT_W-1:0]  stallcnt
);

    logic [31:0]       ins_q,   ins_d;
    logic [31:0]       pc4_q,   pc4_d;
    logic [31:0]       data1_q, data1_d;
    logic [31:0]       data2_q, data2_d;
    logic [31:0]       imm_q,   imm_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              hazard_w;
    upd_e              upd;

    loaduse_detect u_loaduse_detect (
        .ex_valid (valid_q),
        .ex_memrd (ctrl_q[CTRL_MEMRD]),
        .ex_rt    (ins_q[20:16]),
        .id_op    (ifid_ins[31:26]),
        .id_rs    (ifid_ins[25:21]),
        .id_rt    (ifid_ins[20:16]),
        .hazard   (hazard_w)
    );

    // ext_stall outranks flush and hazard: the whole stage freezes.
    always_comb begin
        upd = UPD_LOAD;
        if (ext_stall) begin
            upd = UPD_HOLD;
        end else if (flush || hazard_w) begin
            upd = UPD_BUBBLE;
        end
    end

    always_comb begin
        ins_d   = ins_q;
        pc4_d   = pc4_q;
        data1_d = data1_q;
        data2_d = data2_q;
        imm_d   = imm_q;
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        unique case (upd)
            UPD_LOAD: begin
                ins_d   = ifid_ins;
                pc4_d   = ifid_pc4;
                data1_d = id_rdata1;
                data2_d = id_rdata2;
                imm_d   = id_imm;
                ctrl_d  = id_ctrl;
                valid_d = 1'b1;
            end
            UPD_BUBBLE: begin
                ins_d   = NOP_INS;
                pc4_d   = '0;
                data1_d = '0;
                data2_d = '0;
                imm_d   = '0;
                ctrl_d  = '0;
                valid_d = 1'b0;
            end
            UPD_HOLD: ;
            default: ;
        endcase
    end

    // Counts stall cycles actually taken (not frozen ones); sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (hazard_w && !ext_stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ins_q   <= NOP_INS;
            pc4_q   <= '0;
            data1_q <= '0;
            data2_q <= '0;
            imm_q   <= '0;
            ctrl_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ins_q   <= ins_d;
            pc4_q   <= pc4_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            imm_q   <= imm_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign idexins   = ins_q;
    assign idexpc4   = pc4_q;
    assign idexrs    = ins_q[25:21];
    assign idexrt    = ins_q[20:16];
    assign idexrd    = ins_q[15:11];
    assign idexdata1 = data1_q;
    assign idexdata2 = data2_q;
    assign ideximm   = imm_q;
    assign idexctrl  = ctrl_q;
    assign idexregwr = ctrl_q[CTRL_REGWR];
    assign idexmemwr = ctrl_q[CTRL_MEMWR];
    assign idexmemrd = ctrl_q[CTRL_MEMRD];
    assign idexvalid = valid_q;
    assign hazard    = hazard_w;
    assign pcwr      = !(hazard_w || ext_stall);
    assign ifidwr    = !(hazard_w || ext_stall);
    assign stallcnt  = cnt_q;

endmodule
